// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the cache-side SRAM controller.
// Read lines are 4 halfword phases and write words are 2 halfword phases.
package sram_ctrl_pkg;

  localparam int ADDR_W    = 18;
  localparam int DQ_W      = 16;
  localparam int RD_PHASES = 4;
  localparam int WR_PHASES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit offset of read halfword 'phase' inside the line {hw1,hw0,hw3,hw2}.
  function automatic logic [5:0] line_slot(input logic [1:0] phase);
    case (phase)
      2'd0:    line_slot = 6'd32;
      2'd1:    line_slot = 6'd48;
      2'd2:    line_slot = 6'd0;
      default: line_slot = 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/sram_access_timer.sv
// Per-phase access timer: loads ACC_CYCLES-1 and counts down.
// o_last is high in the final cycle of the current SRAM access phase.
module sram_access_timer #(
  parameter int ACC_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_last
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(ACC_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// Cache-facing SRAM controller: 64-bit line reads and 32-bit word writes over a 16-bit async SRAM.
// Optional protocol checking of the request interface is enabled by defining SRAM_PROTO_CHK_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  input  logic              SRAM_mem_read,
  input  logic              SRAM_mem_write,
  output logic              sram_ready,
  output logic [63:0]       sram_rdata,
  output logic              proto_err,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  state_t          r_state;
  logic [1:0]      r_phase;
  logic [15:0]     r_wdata_hi;
  logic [63:0]     r_line;
  logic            r_dq_oe;
  logic [DQ_W-1:0] r_dq_out;

  logic        w_req;
  logic        w_last;
  logic        w_load;
  logic [63:0] w_line_next;
  logic        w_unused;

  // Read/write handshake: a request is held high until the single-cycle sram_ready pulse;
  // the controller samples it only in IDLE and ignores it while a transaction is in flight.
  assign w_req  = SRAM_mem_read | SRAM_mem_write;
  assign w_load = ((r_state == ST_IDLE) && w_req) ||
                  (((r_state == ST_READ) || (r_state == ST_WRITE)) && w_last);

  assign w_unused = &{1'b0, address[31:17]};

  sram_access_timer #(
    .ACC_CYCLES(ACC_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .i_load(w_load),
    .o_last(w_last)
  );

  always_comb begin
    w_line_next = r_line;
    w_line_next[line_slot(r_phase) +: DQ_W] = SRAM_DQ;
  end

  // Both halfword bytes are always enabled; the controller only does full 16-bit accesses.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = r_dq_oe ? r_dq_out : {DQ_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= 2'd0;
      r_wdata_hi <= '0;
      r_line     <= '0;
      r_dq_oe    <= 1'b0;
      r_dq_out   <= '0;
      sram_ready <= 1'b0;
      sram_rdata <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_CE_N  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          sram_ready <= 1'b0;
          if (w_req) begin
            r_phase    <= 2'd0;
            r_wdata_hi <= wdata[31:16];
            SRAM_CE_N  <= 1'b0;
            if (SRAM_mem_read) begin
              r_state   <= ST_READ;
              SRAM_ADDR <= {address[16:1], 2'b00};
              SRAM_OE_N <= 1'b0;
            end else begin
              r_state   <= ST_WRITE;
              SRAM_ADDR <= {address[16:0], 1'b0};
              SRAM_WE_N <= 1'b0;
              r_dq_oe   <= 1'b1;
              r_dq_out  <= wdata[15:0];
            end
          end
        end
        ST_READ: begin
          if (w_last) begin
            r_line <= w_line_next;
            if (r_phase == 2'(RD_PHASES - 1)) begin
              r_state    <= ST_DONE;
              sram_ready <= 1'b1;
              sram_rdata <= w_line_next;
              SRAM_CE_N  <= 1'b1;
              SRAM_OE_N  <= 1'b1;
            end else begin
              r_phase   <= r_phase + 2'd1;
              SRAM_ADDR <= SRAM_ADDR + ADDR_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (w_last) begin
            if (r_phase == 2'(WR_PHASES - 1)) begin
              r_state    <= ST_DONE;
              sram_ready <= 1'b1;
              SRAM_CE_N  <= 1'b1;
              SRAM_WE_N  <= 1'b1;
              r_dq_oe    <= 1'b0;
            end else begin
              r_phase   <= r_phase + 2'd1;
              SRAM_ADDR <= SRAM_ADDR + ADDR_W'(1);
              r_dq_out  <= r_wdata_hi;
            end
          end
        end
        default: begin
          sram_ready <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_PROTO_CHK_EN
  logic [31:0] r_addr_chk;
  logic [31:0] r_wdata_chk;
  logic        r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_chk  <= '0;
      r_wdata_chk <= '0;
      r_err       <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_addr_chk  <= address;
      r_wdata_chk <= wdata;
      if (SRAM_mem_read && SRAM_mem_write) r_err <= 1'b1;
    end else if ((r_state == ST_READ) &&
                 (!SRAM_mem_read || (address != r_addr_chk))) begin
      r_err <= 1'b1;
    end else if ((r_state == ST_WRITE) &&
                 (!SRAM_mem_write || (address != r_addr_chk) || (wdata != r_wdata_chk))) begin
      r_err <= 1'b1;
    end
  end

  assign proto_err = r_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule
